// File: rtl/conv_pool_engine.sv
// Streaming 3x3 valid convolution over a 14x14 image followed by 2x2/stride-2 max pooling.
// Input is a 196-sample in_valid burst; output is a 36-sample out_valid burst, no backpressure.
module conv_pool_engine #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 36
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  In_IFM,
    input  logic [IN_WIDTH-1:0]  In_Weight,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] Out_OFM,
    output logic [1:0]           state_dbg
);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, OUT} state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [3:0]           row_q, row_d;
    logic [3:0]           col_q, col_d;
    logic [5:0]           out_cnt_q, out_cnt_d;
    logic [IN_WIDTH-1:0]  w_q [9];
    logic [IN_WIDTH-1:0]  w_d [9];
    logic [IN_WIDTH-1:0]  sr_q [30];
    logic [IN_WIDTH-1:0]  sr_d [30];
    logic [OUT_WIDTH-1:0] pair_q, pair_d;
    logic [OUT_WIDTH-1:0] rowmax_q [6];
    logic [OUT_WIDTH-1:0] rowmax_d [6];
    logic [OUT_WIDTH-1:0] res_q [36];
    logic [OUT_WIDTH-1:0] res_d [36];

    logic [IN_WIDTH-1:0]  taps [31];
    logic [OUT_WIDTH-1:0] conv;
    logic                 accept;
    logic [2:0]           pi, pj;
    logic [5:0]           ridx;

    function automatic logic [OUT_WIDTH-1:0] max2(input logic [OUT_WIDTH-1:0] a,
                                                  input logic [OUT_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // taps[d] is the pixel d samples back; window (a,b) sits (2-a) rows and (2-b) cols back.
    always_comb begin
        taps[0] = In_IFM;
        for (int k = 1; k < 31; k++) taps[k] = sr_q[k-1];
        conv = '0;
        for (int k = 0; k < 9; k++)
            conv = conv + OUT_WIDTH'(taps[(2 - k / 3) * 14 + (2 - k % 3)]) * OUT_WIDTH'(w_q[k]);
    end

    assign accept = in_valid && (state_q == IDLE || state_q == LOAD);
    assign pi     = 3'((row_q - 4'd2) >> 1);
    assign pj     = 3'((col_q - 4'd2) >> 1);
    assign ridx   = {3'b000, pi} * 6'd6 + {3'b000, pj};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        out_cnt_d = out_cnt_q;
        w_d       = w_q;
        sr_d      = sr_q;
        pair_d    = pair_q;
        rowmax_d  = rowmax_q;
        res_d     = res_q;

        case (state_q)
            IDLE:    if (in_valid) state_d = LOAD;
            LOAD:    if (accept && cnt_q == 8'd195) state_d = FLUSH;
            FLUSH:   state_d = OUT;
            OUT: begin
                if (out_cnt_q == 6'd35) begin
                    out_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    out_cnt_d = out_cnt_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            sr_d[0] = In_IFM;
            for (int k = 1; k < 30; k++) sr_d[k] = sr_q[k-1];
            if (cnt_q < 8'd9) w_d[cnt_q[3:0]] = In_Weight;

            if (cnt_q == 8'd195) begin
                cnt_d = '0;
                row_d = '0;
                col_d = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
                if (col_q == 4'd13) begin
                    col_d = '0;
                    row_d = row_q + 4'd1;
                end else begin
                    col_d = col_q + 4'd1;
                end
            end

            // Conv row/col parity equals pixel row/col parity (offset of 2).
            if (row_q >= 4'd2 && col_q >= 4'd2) begin
                if (!row_q[0]) begin
                    if (!col_q[0]) pair_d = conv;
                    else           rowmax_d[pj] = max2(pair_q, conv);
                end else begin
                    if (!col_q[0]) pair_d = max2(rowmax_q[pj], conv);
                    else           res_d[ridx] = max2(pair_q, conv);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            out_cnt_q <= '0;
            w_q       <= '{default: '0};
            sr_q      <= '{default: '0};
            pair_q    <= '0;
            rowmax_q  <= '{default: '0};
            res_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
            out_cnt_q <= out_cnt_d;
            w_q       <= w_d;
            sr_q      <= sr_d;
            pair_q    <= pair_d;
            rowmax_q  <= rowmax_d;
            res_q     <= res_d;
        end
    end

    assign out_valid = (state_q == OUT);
    assign Out_OFM   = out_valid ? res_q[out_cnt_q] : '0;
    assign state_dbg = state_q;
endmodule

// File: doc/conv_pool_engine.md
CONV_POOL_ENGINE -- requirements
Module: conv_pool_engine

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, meaning input pixel and weight width.
REQ-002 SHALL have parameter OUT_WIDTH, default 36, meaning result width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  high for the 196 consecutive cycles of one pattern.
REQ-006 SHALL have port In_IFM  input  IN_WIDTH  unsigned image pixel, 14x14 row-major, one per in_valid cycle.
REQ-007 SHALL have port In_Weight  input  IN_WIDTH  unsigned 3x3 kernel, row-major; valid only in the first 9 in_valid cycles.
REQ-008 SHALL have port out_valid  output  1  high for exactly 36 consecutive cycles per pattern.
REQ-009 SHALL have port Out_OFM  output  OUT_WIDTH  pooled result, 6x6 row-major; 0 whenever out_valid is low.

Function
REQ-010 SHALL compute conv(i,j) = sum over a,b in 0..2 of pix(i+a,j+b)*w(a,b) for i,j in 0..11 (valid 3x3, stride 1, unsigned).
REQ-011 SHALL compute out(p,q) = max of conv(2p..2p+1, 2q..2q+1) for p,q in 0..5 (2x2 max pool, stride 2, unsigned compare).
REQ-012 SHALL hold full 36-bit precision with no truncation or saturation (9 x 65535^2 < 2^36).
REQ-013 SHALL implement FSM IDLE -> LOAD -> FLUSH -> OUT -> IDLE.
REQ-014 SHALL leave IDLE for LOAD on the first cycle in_valid is sampled high; that sample is pixel 0 and weight 0.
REQ-015 SHALL latch weights on in_valid cycles 0..8 only; In_Weight (including X) ignored afterwards.
REQ-016 SHALL track pixel position with an 8-bit counter 0..195 and move LOAD -> FLUSH after sample 195.
REQ-017 SHALL stream: two-row line buffer plus 3x3 window; a conv result is produced per pixel with row>=2 and col>=2.
REQ-018 SHALL pool on the fly: even conv rows kept as 6 pairwise maxima, combined with the odd conv row; pooled values written to a 36-entry result buffer.
REQ-019 SHALL ignore in_valid in FLUSH and OUT states (no acceptance, no corruption).
REQ-020 SHALL assert out_valid first no earlier than the cycle after the last in_valid cycle and no later than 8 cycles after it; latency is a fixed constant.
REQ-021 SHALL drive results in index order 0..35 on 36 contiguous cycles; out_valid never drops mid-burst.
REQ-022 SHALL drop out_valid and Out_OFM to 0 in the cycle after result 35 and return to IDLE.
REQ-023 SHALL accept a new pattern from IDLE any cycle after return, with no stale weights, line-buffer or pool data affecting it.

Reset
REQ-024 SHALL, while rst is high, immediately force out_valid=0, Out_OFM=0, FSM=IDLE, all counters 0.
REQ-025 SHALL abandon any partial pattern when rst asserts mid-LOAD/FLUSH/OUT; no output emitted for it after release.
REQ-026 SHALL keep outputs 0 after rst release until a complete pattern is received.

Verification
REQ-027 SHALL pass: rst high for 10 cycles, inputs X -> out_valid=0, Out_OFM=0 throughout and after release.
REQ-028 SHALL pass: all pixels 1, all weights 1 -> 36 outputs of 9, contiguous, within 8 cycles of last input.
REQ-029 SHALL pass: pix(r,c)=14r+c, weights center 1 else 0 -> out(p,q)=(2p+2)*14+2q+2; out[0]=30, out[35]=180.
REQ-030 SHALL pass: all pixels and weights 65535 -> every output 38653526025.
REQ-031 SHALL pass: two random patterns, second in_valid 4 cycles after first burst ends, In_Weight=X after 9 cycles -> both match golden model.
REQ-032 SHALL pass: rst pulsed at input cycle 100, then full pattern -> no output for aborted pattern; new pattern matches golden.
